imem_loadable: RTL and testbench
================================

# imem_loadable

Parametrised, byte-addressable instruction memory for the RISC-V core, with a serial byte-loader port and a registered fetch port. Programs are streamed in over the loader at run time instead of being hard-wired, and the core fetches little-endian 32-bit words with one-cycle latency. It sits between the program counter and the decode/control stage, with the loader driven by the testbench or a host interface.

## Interface
- DEPTH_BYTES, 128: storage size in bytes; power of two, minimum 8.
- ADDR_W, 32: width of `fetch_pc`.
- NOP_WORD, 32'h00000013: word returned on a faulted fetch (`addi x0,x0,0`).

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- load_en  in  1  high for the duration of a program load
- load_valid  in  1  `load_data` valid this cycle
- load_data  in  8  byte to store at the current write pointer
- load_ready  out  1  loader accepts a byte this cycle
- load_done  out  1  one-cycle pulse when a load session ends
- load_count  out  $clog2(DEPTH_BYTES)+1  bytes written in the last completed session
- busy  out  1  high while in LOAD; fetches are ignored
- fetch_req  in  1  fetch request, sampled on the clock edge
- fetch_pc  in  ADDR_W  byte address of the instruction
- fetch_valid  out  1  `instruction_code` / `fetch_fault` valid this cycle
- instruction_code  out  32  fetched word, {mem[pc+3], mem[pc+2], mem[pc+1], mem[pc]}
- fetch_fault  out  1  fetch address misaligned or out of range

## Operation
- FSM states: IDLE, LOAD.
  - IDLE -> LOAD when `load_en` is high. The write pointer clears to 0.
  - LOAD -> IDLE on either of:
    - `load_en` low, or
    - the byte at address DEPTH_BYTES-1 is accepted. `load_en` must then drop before a new session can start; a new session starts only after IDLE sees `load_en` low for one or more cycles.
  - On LOAD exit: `load_done` pulses for 1 cycle and `load_count` is set to the write pointer value.
- LOAD:
  - `load_ready` = 1 and `busy` = 1.
  - Each cycle with `load_valid && load_ready`, write mem[ptr] = `load_data` and increment ptr.
  - `fetch_req` is ignored: no `fetch_valid` is produced.
- IDLE:
  - `load_ready` = 0.
  - `fetch_req` captures `fetch_pc`, and the response is registered.
  - Back-to-back requests give one response per cycle.
  - If `load_en` and `fetch_req` are both high in IDLE, the fetch is served from the pre-load contents and LOAD starts on the next cycle.
- Memory contents are not cleared by reset. Contents are undefined until the first load.

## Timing
- Fetch latency: `fetch_req` at edge N gives `fetch_valid` = 1 during cycle N+1. `fetch_valid` is 0 in any cycle with no accepted request. `instruction_code` holds its last value when `fetch_valid` = 0.
- Loader: one byte per cycle maximum. `load_ready` rises in the first cycle after the edge that enters LOAD.
- `load_done` is asserted in the cycle after the last accepted byte, or after `load_en` drops.
- Reset values: `fetch_valid`=0, `instruction_code`=0, `fetch_fault`=0, `load_ready`=0, `load_done`=0, `load_count`=0, `busy`=0. State = IDLE, pointer = 0.
- Reset during LOAD:
  - Return to IDLE immediately.
  - Bytes already written are kept.
  - No `load_done` pulse; `load_count` reads 0.
- A reset that asserts while a fetch is pending drops the response.

## Configuration
- `IMEM_BOUNDS_CHECK_EN` defined:
  - A fetch is faulted when `fetch_pc[1:0] != 0` or `fetch_pc > DEPTH_BYTES-4`.
  - A faulted fetch returns `fetch_valid`=1, `fetch_fault`=1, `instruction_code`=NOP_WORD.
  - A faulted fetch performs no memory read.
- Not defined:
  - `fetch_pc[1:0]` is ignored (word aligned), and the address is taken modulo DEPTH_BYTES.
  - `fetch_fault` is tied to 0.

## Test plan
- Load 8 bytes 33 03 94 00 b3 00 01 80, then drop `load_en`. Required: `load_done` pulse, `load_count`=8. Fetch pc=0 returns 32'h00940333; fetch pc=4 returns 32'h800100b3, each one cycle after its request.
- Back-to-back fetches at pc=0, 4, 0 on consecutive edges. Required: three consecutive `fetch_valid` cycles, with data in request order.
- Stream DEPTH_BYTES bytes with `load_en` held high. Required: auto-exit after byte 127, `load_count`=128, `load_ready` low afterwards. No new session starts until `load_en` is toggled.
- `fetch_req` during LOAD gives no `fetch_valid`. `fetch_req` in the same cycle as `load_en` rising returns the old word.
- Pull `reset` low after 3 loaded bytes. Required: outputs go to their reset values asynchronously; a fetch of pc=0 after release returns the 3 written bytes plus the prior upper byte.
- With `IMEM_BOUNDS_CHECK_EN`: pc=2 and pc=128 each give `fetch_fault`=1 and 32'h00000013. Without it: pc=130 returns the word at pc=0 and `fetch_fault`=0.

Source files
------------

// File: rtl/imem_loadable.sv
// Byte-addressable instruction memory with a serial byte loader and a registered 32-bit fetch port.
// Define IMEM_BOUNDS_CHECK_EN to fault misaligned or out-of-range fetches instead of wrapping them.
module imem_loadable #(
  parameter int unsigned DEPTH_BYTES = 128,
  parameter int unsigned ADDR_W      = 32,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load_en,
  input  logic                           load_valid,
  input  logic [7:0]                     load_data,
  output logic                           load_ready,
  output logic                           load_done,
  output logic [$clog2(DEPTH_BYTES):0]   load_count,
  output logic                           busy,
  input  logic                           fetch_req,
  input  logic [ADDR_W-1:0]              fetch_pc,
  output logic                           fetch_valid,
  output logic [31:0]                    instruction_code,
  output logic                           fetch_fault
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    IDLE,
    LOAD
  } state_t;

  state_t         state;
  logic [AW-1:0]  ptr;
  logic           wait_low;
  logic [7:0]     mem [DEPTH_BYTES];

  logic           accept;
  logic           last_byte;
  logic [AW-3:0]  widx;
  logic [31:0]    rd_word;
  logic           fault_c;

  assign accept    = (state == LOAD) && load_valid;
  assign last_byte = (ptr == AW'(DEPTH_BYTES - 1));
  assign widx      = fetch_pc[AW-1:2];

  // Storage has no reset so contents survive a reset pulse mid-load.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[ptr] <= load_data;
    end
  end

  always_comb begin
    rd_word = {mem[{widx, 2'b11}], mem[{widx, 2'b10}], mem[{widx, 2'b01}], mem[{widx, 2'b00}]};
  end

`ifdef IMEM_BOUNDS_CHECK_EN
  always_comb begin
    fault_c = (fetch_pc[1:0] != 2'b00) || (fetch_pc > ADDR_W'(DEPTH_BYTES - 4));
  end
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[ADDR_W-1:AW], fetch_pc[1:0]};

  always_comb begin
    fault_c = 1'b0;
  end
`endif

  // wait_low blocks re-entry after a full-memory auto-exit until load_en has been seen low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      wait_low   <= 1'b0;
      load_ready <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_count <= '0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!load_en) begin
            wait_low <= 1'b0;
          end
          if (load_en && !wait_low) begin
            state      <= LOAD;
            ptr        <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            ptr <= ptr + AW'(1);
          end
          if (!load_en || (accept && last_byte)) begin
            state      <= IDLE;
            load_ready <= 1'b0;
            busy       <= 1'b0;
            load_done  <= 1'b1;
            load_count <= CW'(ptr) + CW'(accept);
            wait_low   <= load_en;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_valid      <= 1'b0;
      instruction_code <= '0;
      fetch_fault      <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      if ((state == IDLE) && fetch_req) begin
        fetch_valid      <= 1'b1;
        fetch_fault      <= fault_c;
        instruction_code <= fault_c ? NOP_WORD : rd_word;
      end
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: stimulus pushes expected fetch responses, a monitor pops and compares.
module tb_imem_loadable;

  localparam int unsigned DEPTH = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_en = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = '0;
  logic        load_ready;
  logic        load_done;
  logic [7:0]  load_count;
  logic        busy;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_valid;
  logic [31:0] instruction_code;
  logic        fetch_fault;

  imem_loadable #(
    .DEPTH_BYTES(DEPTH),
    .ADDR_W(32),
    .NOP_WORD(32'h00000013)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_en(load_en),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .load_done(load_done),
    .load_count(load_count),
    .busy(busy),
    .fetch_req(fetch_req),
    .fetch_pc(fetch_pc),
    .fetch_valid(fetch_valid),
    .instruction_code(instruction_code),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] code;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  logic [7:0] prog [8] = '{8'h33, 8'h03, 8'h94, 8'h00, 8'hb3, 8'h00, 8'h01, 8'h80};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] code, input logic fault);
    exp_t e;
    fetch_req = 1'b1;
    fetch_pc  = pc;
    e.code  = code;
    e.fault = fault;
    e.cyc   = cyc + 1;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && fetch_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_fetch_valid: got valid at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("fetch_data", instruction_code, e.code);
        chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, e.fault});
        chk("fetch_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #12;
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_instr", instruction_code, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_load_ready", {31'b0, load_ready}, 32'd0);
    chk("rst_load_done", {31'b0, load_done}, 32'd0);
    chk("rst_load_count", {24'b0, load_count}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b1;
    tick();

    // 8-byte program, session ended by dropping load_en
    load_en = 1'b1;
    tick();
    chk("load_busy", {31'b0, busy}, 32'd1);
    chk("load_ready_hi", {31'b0, load_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      tick();
    end
    load_valid = 1'b0;
    load_en    = 1'b0;
    tick();
    chk("done_pulse8", {31'b0, load_done}, 32'd1);
    chk("count8", {24'b0, load_count}, 32'd8);
    chk("busy_after8", {31'b0, busy}, 32'd0);
    tick();
    chk("done_clear8", {31'b0, load_done}, 32'd0);

    issue(32'd0, 32'h00940333, 1'b0); tick(); fetch_req = 1'b0; tick();
    issue(32'd4, 32'h800100b3, 1'b0); tick(); fetch_req = 1'b0; tick();

    // back-to-back fetches
    issue(32'd0, 32'h00940333, 1'b0); tick();
    issue(32'd4, 32'h800100b3, 1'b0); tick();
    issue(32'd0, 32'h00940333, 1'b0); tick();
    fetch_req = 1'b0;
    tick(); tick();

    // full-memory load with load_en held high: byte i = i
    load_en = 1'b1;
    tick();
    for (int i = 0; i < int'(DEPTH); i++) begin
      load_valid = 1'b1;
      load_data  = 8'(i);
      tick();
    end
    load_valid = 1'b0;
    chk("done_pulse_full", {31'b0, load_done}, 32'd1);
    chk("count_full", {24'b0, load_count}, 32'd128);
    chk("ready_low_full", {31'b0, load_ready}, 32'd0);
    chk("busy_low_full", {31'b0, busy}, 32'd0);
    tick();
    chk("done_clear_full", {31'b0, load_done}, 32'd0);
    chk("no_restart_1", {31'b0, busy}, 32'd0);
    tick();
    chk("no_restart_2", {31'b0, load_ready}, 32'd0);
    load_en = 1'b0;
    tick();

    issue(32'd124, 32'h7f7e7d7c, 1'b0); tick(); fetch_req = 1'b0; tick();
    issue(32'd0, 32'h03020100, 1'b0); tick(); fetch_req = 1'b0; tick();

    // fetch on the load_en rising cycle returns the old word; fetches during LOAD are dropped
    issue(32'd0, 32'h03020100, 1'b0);
    load_en = 1'b1;
    tick();
    fetch_pc = 32'd4;
    chk("busy_in_load", {31'b0, busy}, 32'd1);
    tick(); tick();
    fetch_req = 1'b0;
    load_valid = 1'b1; load_data = 8'haa; tick();
    load_data = 8'hbb; tick();
    load_data = 8'hcc; tick();
    load_valid = 1'b0;

    // asynchronous reset mid-load
    #1 reset = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_ready", {31'b0, load_ready}, 32'd0);
    chk("arst_count", {24'b0, load_count}, 32'd0);
    chk("arst_done", {31'b0, load_done}, 32'd0);
    chk("arst_fvalid", {31'b0, fetch_valid}, 32'd0);
    chk("arst_instr", instruction_code, 32'd0);
    load_en = 1'b0;
    #1 reset = 1'b1;
    tick();
    chk("post_rst_done", {31'b0, load_done}, 32'd0);
    chk("post_rst_count", {24'b0, load_count}, 32'd0);

    issue(32'd0, 32'h03ccbbaa, 1'b0); tick(); fetch_req = 1'b0; tick();

`ifdef IMEM_BOUNDS_CHECK_EN
    issue(32'd2, 32'h00000013, 1'b1); tick();
    issue(32'd128, 32'h00000013, 1'b1); tick();
    issue(32'd124, 32'h7f7e7d7c, 1'b0); tick();
`else
    issue(32'd130, 32'h03ccbbaa, 1'b0); tick();
    issue(32'd2, 32'h03ccbbaa, 1'b0); tick();
    issue(32'd252, 32'h7f7e7d7c, 1'b0); tick();
`endif
    fetch_req = 1'b0;
    tick(); tick();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
